sync_fifo_ctrl: RTL
===================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that drives an external 64x8 dual-port SRAM.
//  - Owns the read/write pointers, full/empty status and occupancy count.
//  - Generates the SRAM write strobe and both SRAM addresses.
//  - Re-times the SRAM's 1-cycle registered read data into a valid-qualified output.
//  - Sits between the producer/consumer logic and the SRAM, with both SRAM clocks tied to `clock`.
// PARAMETERS
//  DATA_W   8   data width; must match the SRAM word width
//  ADDR_W   6   SRAM address width; DEPTH = 2**ADDR_W = 64 entries
// PORTS
//  clock       in   1         single clock; rising edge; also drives SRAM r_clock/w_clock
//  reset       in   1         synchronous, active-high
//  wr_req      in   1         push request
//  wr_data     in   DATA_W    push data
//  rd_req      in   1         pop request
//  rd_data     out  DATA_W    popped data; meaningful only while rd_valid=1
//  rd_valid    out  1         rd_data holds the word popped on the previous cycle
//  full        out  1         count == DEPTH
//  empty       out  1         count == 0
//  count       out  ADDR_W+1  occupancy, 0..DEPTH
//  ram_we      out  1         SRAM write enable
//  ram_w_addr  out  ADDR_W    SRAM write address
//  ram_data    out  DATA_W    SRAM write data (= wr_data)
//  ram_r_addr  out  ADDR_W    SRAM read address
//  ram_q       in   DATA_W    SRAM registered read data
// BEHAVIOUR
//  Clock and reset:
//  - One clock. Reset is synchronous and active-high.
//  - On reset: wptr=0, rptr=0, count=0, empty=1, full=0, rd_valid=0.
//  - Reset mid-operation drops any pending rd_valid. SRAM contents are not cleared.
//  Pointers:
//  - wptr and rptr are ADDR_W+1 bits and wrap modulo 2*DEPTH.
//  - SRAM addresses are ptr[ADDR_W-1:0].
//  - full  = (wptr[ADDR_W] != rptr[ADDR_W]) && (low bits equal).
//  - empty = (wptr == rptr).
//  - full and empty are registered, or derived from registered pointers. No combinational path from wr_req/rd_req.
//  Push:
//  - Accept when wr_req && !full.
//  - ram_we = accept (combinational). ram_w_addr = wptr. wptr increments at the edge.
//  Pop:
//  - Accept when rd_req && !empty.
//  - ram_r_addr = rptr is always driven; rptr increments at the edge.
//  - rd_valid=1 the following cycle, and rd_data = ram_q in that cycle.
//  - Read latency is exactly 1 cycle. Back-to-back pops give one word per cycle.
//  Simultaneous events:
//  - Push and pop both accepted: count unchanged, both pointers advance.
//  - Full with push and pop: pop accepted, push rejected. full is evaluated on the pre-edge state.
//  - Empty with push and pop: push accepted, pop rejected. There is no write-to-read bypass.
//  - First pop is possible the cycle after the first push. The SRAM write lands on that same edge, so the pop reads the new data.
//  Rejected requests:
//  - Push while full or pop while empty: ignored.
//  - Pointers, count and SRAM are unchanged.
//  Arithmetic:
//  - count is ADDR_W+1 bits: +1 on push-only, -1 on pop-only, unchanged otherwise. Never wraps.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//  - Adds outputs `overflow` and `underflow` (1 bit each, reset 0).
//  - overflow sets sticky on the cycle after wr_req && full.
//  - underflow sets sticky on the cycle after rd_req && empty.
//  - Cleared only by reset.
//  FIFO_ERR_FLAGS_EN undefined:
//  - Ports and logic are absent. Rejected requests are silent.
// STRUCTURE
//  sync_fifo_pkg holds:
//  - DATA_W/ADDR_W defaults and the DEPTH localparam.
//  - The pointer type width, ADDR_W+1.
//  - count_next function: inc/dec/hold encoding.
//  Sub-module fifo_ptr (ADDR_W+1 counter with enable and sync reset):
//  - Instantiated twice, for wptr and rptr.
//  Top level holds:
//  - Flag logic.
//  - rd_valid register.
//  - Error flags.
//  - SRAM port wiring.
// TESTING
//  Bench instantiates the 64x8 dual-port SRAM with both clocks on `clock`.
//  1 Reset, then push 0x11,0x22,0x33 -> count=3, empty=0. Pop 3 -> rd_data 0x11,0x22,0x33, each with rd_valid the cycle after its pop.
//  2 Push 64 words 0x00..0x3F -> full=1 at count=64. 65th push (0xAA) ignored. Drain all -> 0x00..0x3F in order, then empty=1.
//  3 Full, then simultaneous push 0x55 and pop -> pop returns oldest word, 0x55 rejected, count=63.
//     Empty, then simultaneous push 0x77 and pop -> push only, count=1. Next-cycle pop returns 0x77.
//  4 Wrap: 200 random push/pop cycles at ~50% each, checked against a reference queue model.
//     -> pointers wrap past 127, data and count match every cycle.
//  5 Reset asserted the cycle after a pop -> rd_valid=0 next cycle, count=0, empty=1. Subsequent push/pop behave as in scenario 1.
//  6 With FIFO_ERR_FLAGS_EN: pop on empty -> underflow=1 and it stays 1. Push on full -> overflow=1. Reset clears both.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths and the occupancy-update encoding for sync_fifo_ctrl
package sync_fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int PTR_W      = ADDR_W_DEF + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {CNT_HOLD, CNT_INC, CNT_DEC} cnt_op_e;

    // Push-only grows the FIFO, pop-only shrinks it, anything else leaves it alone
    function automatic cnt_op_e count_next(input logic push, input logic pop);
        return (push && !pop) ? CNT_INC : (pop && !push) ? CNT_DEC : CNT_HOLD;
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-around pointer with enable and synchronous reset
module fifo_ptr #(
    parameter int W = sync_fifo_pkg::PTR_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);
    logic [W-1:0] ptr_q;

    // Step by one per accepted transfer; the extra MSB lets full and empty be told apart
    always_ff @(posedge clock) ptr_q <= reset ? '0 : ptr_q + W'(en_i);

    assign ptr_o = ptr_q;
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller for an external dual-port SRAM
// Optional sticky overflow/underflow outputs are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_r_addr,
    input  logic [DATA_W-1:0] ram_q
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);
    logic [ADDR_W:0] wptr, rptr;
    logic [ADDR_W:0] count_q, count_d;
    logic            rd_valid_q;
    logic            push, pop;
    cnt_op_e         op;

    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty = (wptr == rptr);
    assign push  = wr_req && !full;
    assign pop   = rd_req && !empty;
    assign op    = count_next(push, pop);

    fifo_ptr #(.W(ADDR_W + 1)) u_wptr (.clock(clock), .reset(reset), .en_i(push), .ptr_o(wptr));
    fifo_ptr #(.W(ADDR_W + 1)) u_rptr (.clock(clock), .reset(reset), .en_i(pop),  .ptr_o(rptr));

    assign ram_we     = push;
    assign ram_w_addr = wptr[ADDR_W-1:0];
    assign ram_data   = wr_data;
    assign ram_r_addr = rptr[ADDR_W-1:0];
    assign rd_data    = ram_q;
    assign rd_valid   = rd_valid_q;
    assign count      = count_q;

    // Occupancy update; full/empty already block the cases that could wrap it
    always_comb begin
        count_d = count_q;
        count_d = (op == CNT_INC) ? count_q + 1'b1 : (op == CNT_DEC) ? count_q - 1'b1 : count_q;
    end

    // Occupancy register and the one-cycle valid that tracks the SRAM read latency
    always_ff @(posedge clock) begin
        count_q    <= reset ? '0 : count_d;
        rd_valid_q <= reset ? 1'b0 : pop;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags: set by a request against full/empty, cleared only by reset
    always_ff @(posedge clock) begin
        overflow_q  <= reset ? 1'b0 : overflow_q  | (wr_req && full);
        underflow_q <= reset ? 1'b0 : underflow_q | (rd_req && empty);
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule
